v33_bus_target: RTL and testbench

Bus target (responder) for the V33 external bus. It sits on the far side of the CPU's bus control unit pins. It decodes each bus cycle from n_bcyst, m_io, r_w, busst1/busst0, n_ube and addr, and translates memory and I/O cycles into a single req/ack backend port. It answers interrupt-acknowledge and halt-acknowledge cycles itself and paces every cycle through n_ready with programmable wait states.

---
 rtl/v33_bus_target.sv | 238 +++++++++++++++++++++++
 tb/tb_v33_bus_target.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v33_bus_target.sv
// v33_bus_target: responder on the far side of the V33 bus control pins.
// Decodes each bus cycle, forwards memory and I/O cycles to a single req/ack
// backend port, answers INTA and HALT cycles locally and paces every cycle
// through a registered, active-low n_ready with programmable wait states.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ce_1, ce_2          CPU bus phase enables
//   n_bcyst .. n_ube    CPU bus status pins; addr / cpu_dout address and write data
//   cpu_din, n_ready    read data and ready back to the CPU
//   mem_*               backend request port (level req, one-clk ack)
//   int_vector          vector returned on the second INTA cycle
//   intack_done, halt_ack, bus_error   one-clk status pulses
module v33_bus_target #(
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned IO_WAIT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_1,
    input  logic        ce_2,
    input  logic        n_bcyst,
    input  logic        n_dstb,
    input  logic        r_w,
    input  logic        m_io,
    input  logic        busst0,
    input  logic        busst1,
    input  logic        n_ube,
    input  logic [23:0] addr,
    input  logic [15:0] cpu_dout,
    output logic [15:0] cpu_din,
    output logic        n_ready,
    output logic        mem_req,
    output logic        mem_io,
    output logic        mem_we,
    output logic [22:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    input  logic [7:0]  int_vector,
    output logic        intack_done,
    output logic        halt_ack,
    output logic        bus_error
);

    typedef enum logic [1:0] {StIdle, StAddr, StAccess, StReady} state_e;
    typedef enum logic [2:0] {CyMem, CyIo, CyInta, CyHalt, CyBad} cycle_e;

    localparam logic [3:0] MemWait = 4'(MEM_WAIT);
    localparam logic [3:0] IoWait  = 4'(IO_WAIT);

    // Data strobe timing is implied by the phase enables; the pin is not needed.
    logic unused_n_dstb;
    assign unused_n_dstb = n_dstb;

    state_e      state_q, state_d;
    cycle_e      cyc_q, cyc_d, cyc_dec;
    logic        read_q, read_d;
    logic [3:0]  wait_q, wait_d;
    logic        ack_q, ack_d;
    logic        inta_phase_q, inta_phase_d;
    logic        second_q, second_d;
    logic [15:0] cpu_din_q, cpu_din_d;
    logic        n_ready_q, n_ready_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_io_q, mem_io_d;
    logic        mem_we_q, mem_we_d;
    logic [22:0] mem_addr_q, mem_addr_d;
    logic [1:0]  mem_be_q, mem_be_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        intack_done_q, intack_done_d;
    logic        halt_ack_q, halt_ack_d;
    logic        bus_error_q, bus_error_d;

    logic new_start, ack_now, ready_go, is_backend;

    assign new_start  = ce_2 & ~n_bcyst;
    // A stray ack while no request is outstanding is ignored.
    assign ack_now    = (state_q == StAccess) & mem_ack & mem_req_q;
    // Falling on the ack clk itself lets an early ack finish with no wait state.
    assign ready_go   = (state_q == StAccess) & (ack_q | ack_now) & (wait_q == 4'd0);
    assign is_backend = (cyc_q == CyMem) | (cyc_q == CyIo);

    always_comb begin
        if (m_io) begin
            cyc_dec = CyMem;
        end else begin
            case ({busst1, busst0})
                2'b01:   cyc_dec = CyIo;
                2'b00:   cyc_dec = r_w ? CyInta : CyBad;
                2'b11:   cyc_dec = r_w ? CyBad : CyHalt;
                default: cyc_dec = CyBad;
            endcase
        end
    end

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cyc_q         <= CyMem;
            read_q        <= 1'b0;
            wait_q        <= 4'd0;
            ack_q         <= 1'b0;
            inta_phase_q  <= 1'b0;
            second_q      <= 1'b0;
            cpu_din_q     <= 16'hFFFF;
            n_ready_q     <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_io_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 23'd0;
            mem_be_q      <= 2'b00;
            mem_wdata_q   <= 16'd0;
            intack_done_q <= 1'b0;
            halt_ack_q    <= 1'b0;
            bus_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            read_q        <= read_d;
            wait_q        <= wait_d;
            ack_q         <= ack_d;
            inta_phase_q  <= inta_phase_d;
            second_q      <= second_d;
            cpu_din_q     <= cpu_din_d;
            n_ready_q     <= n_ready_d;
            mem_req_q     <= mem_req_d;
            mem_io_q      <= mem_io_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_be_q      <= mem_be_d;
            mem_wdata_q   <= mem_wdata_d;
            intack_done_q <= intack_done_d;
            halt_ack_q    <= halt_ack_d;
            bus_error_q   <= bus_error_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (new_start) state_d = StAddr;
            StAddr:   if (ce_1) state_d = StAccess;
            StAccess: if (ready_go) state_d = StReady;
            StReady:  if (ce_2) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        cyc_d         = cyc_q;
        read_d        = read_q;
        wait_d        = wait_q;
        ack_d         = ack_q;
        inta_phase_d  = inta_phase_q;
        second_d      = second_q;
        cpu_din_d     = cpu_din_q;
        n_ready_d     = n_ready_q;
        mem_req_d     = mem_req_q;
        mem_io_d      = mem_io_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_be_d      = mem_be_q;
        mem_wdata_d   = mem_wdata_q;
        intack_done_d = 1'b0;
        halt_ack_d    = 1'b0;
        // A new cycle start while busy is flagged and otherwise ignored.
        bus_error_d   = new_start & (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (new_start) begin
                    cyc_d      = cyc_dec;
                    read_d     = r_w;
                    ack_d      = 1'b0;
                    mem_addr_d = addr[23:1];
                    mem_be_d   = {~n_ube, ~addr[0]};
                    mem_io_d   = (cyc_dec == CyIo);
                    mem_we_d   = ((cyc_dec == CyMem) | (cyc_dec == CyIo)) & ~r_w;
                    wait_d     = (cyc_dec == CyMem) ? MemWait : IoWait;
                    if (cyc_dec == CyBad) bus_error_d = 1'b1;
                end
            end
            StAddr: begin
                if (ce_1) begin
                    mem_wdata_d  = cpu_dout;
                    inta_phase_d = (cyc_q == CyInta) ? ~inta_phase_q : 1'b0;
                    second_d     = (cyc_q == CyInta) & inta_phase_q;
                    if (is_backend) begin
                        mem_req_d = 1'b1;
                    end else begin
                        // Locally answered cycles need no backend ack.
                        ack_d = 1'b1;
                        case (cyc_q)
                            CyInta:  cpu_din_d = inta_phase_q ? {8'hFF, int_vector} : 16'hFFFF;
                            CyBad:   cpu_din_d = 16'hFFFF;
                            default: ;
                        endcase
                    end
                end
            end
            StAccess: begin
                if (ce_2 && wait_q != 4'd0) wait_d = wait_q - 4'd1;
                if (ack_now) begin
                    mem_req_d = 1'b0;
                    ack_d     = 1'b1;
                    if (read_q) cpu_din_d = mem_rdata;
                end
                if (ready_go) n_ready_d = 1'b0;
            end
            StReady: begin
                if (ce_2) begin
                    n_ready_d     = 1'b1;
                    intack_done_d = (cyc_q == CyInta) & second_q;
                    halt_ack_d    = (cyc_q == CyHalt);
                end
            end
            default: ;
        endcase
    end

    assign cpu_din     = cpu_din_q;
    assign n_ready     = n_ready_q;
    assign mem_req     = mem_req_q;
    assign mem_io      = mem_io_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_be      = mem_be_q;
    assign mem_wdata   = mem_wdata_q;
    assign intack_done = intack_done_q;
    assign halt_ack    = halt_ack_q;
    assign bus_error   = bus_error_q;

endmodule

// File: tb/tb_v33_bus_target.sv
// Testbench for v33_bus_target: a simple CPU bus model drives cycles, a backend
// model answers requests, and a monitor pops expected requests/completions
// from scoreboard queues. Two instances run in lockstep: dut (MEM_WAIT=0) and
// dut_w (MEM_WAIT=2); sel picks whose outputs the CPU and monitor follow.
module tb_v33_bus_target;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, ce_1 = 1'b0, ce_2 = 1'b0;
    logic        n_bcyst = 1'b1, n_dstb = 1'b1, r_w = 1'b1, m_io = 1'b1;
    logic        busst0 = 1'b0, busst1 = 1'b0, n_ube = 1'b1;
    logic [23:0] addr = 24'd0;
    logic [15:0] cpu_dout = 16'd0, mem_rdata = 16'd0;
    logic        mem_ack = 1'b0;
    logic [7:0]  int_vector = 8'd0;

    logic [15:0] d0_cpu_din, d1_cpu_din, d0_mem_wdata, d1_mem_wdata;
    logic        d0_n_ready, d1_n_ready, d0_mem_req, d1_mem_req;
    logic        d0_mem_io, d1_mem_io, d0_mem_we, d1_mem_we;
    logic [22:0] d0_mem_addr, d1_mem_addr;
    logic [1:0]  d0_mem_be, d1_mem_be;
    logic        d0_intack, d1_intack, d0_halt, d1_halt, d0_berr, d1_berr;

    v33_bus_target #(.MEM_WAIT(0), .IO_WAIT(1)) dut (
        .clk(clk), .reset(reset), .ce_1(ce_1), .ce_2(ce_2), .n_bcyst(n_bcyst),
        .n_dstb(n_dstb), .r_w(r_w), .m_io(m_io), .busst0(busst0), .busst1(busst1),
        .n_ube(n_ube), .addr(addr), .cpu_dout(cpu_dout), .cpu_din(d0_cpu_din),
        .n_ready(d0_n_ready), .mem_req(d0_mem_req), .mem_io(d0_mem_io),
        .mem_we(d0_mem_we), .mem_addr(d0_mem_addr), .mem_be(d0_mem_be),
        .mem_wdata(d0_mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .int_vector(int_vector), .intack_done(d0_intack), .halt_ack(d0_halt),
        .bus_error(d0_berr)
    );

    v33_bus_target #(.MEM_WAIT(2), .IO_WAIT(1)) dut_w (
        .clk(clk), .reset(reset), .ce_1(ce_1), .ce_2(ce_2), .n_bcyst(n_bcyst),
        .n_dstb(n_dstb), .r_w(r_w), .m_io(m_io), .busst0(busst0), .busst1(busst1),
        .n_ube(n_ube), .addr(addr), .cpu_dout(cpu_dout), .cpu_din(d1_cpu_din),
        .n_ready(d1_n_ready), .mem_req(d1_mem_req), .mem_io(d1_mem_io),
        .mem_we(d1_mem_we), .mem_addr(d1_mem_addr), .mem_be(d1_mem_be),
        .mem_wdata(d1_mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .int_vector(int_vector), .intack_done(d1_intack), .halt_ack(d1_halt),
        .bus_error(d1_berr)
    );

    logic sel = 1'b0;
    logic [15:0] cpu_din_s;
    logic        n_ready_s, mem_req_s, intack_s, halt_s;
    logic [43:0] req_s;
    assign cpu_din_s = sel ? d1_cpu_din : d0_cpu_din;
    assign n_ready_s = sel ? d1_n_ready : d0_n_ready;
    assign mem_req_s = sel ? d1_mem_req : d0_mem_req;
    assign intack_s  = sel ? d1_intack : d0_intack;
    assign halt_s    = sel ? d1_halt : d0_halt;
    assign req_s = sel ? {d1_mem_io, d1_mem_we, d1_mem_addr, d1_mem_be, d1_mem_wdata}
                       : {d0_mem_io, d0_mem_we, d0_mem_addr, d0_mem_be, d0_mem_wdata};

    typedef struct packed {
        logic        io;
        logic        we;
        logic [22:0] a;
        logic [1:0]  be;
        logic [15:0] wd;
    } req_t;
    typedef struct packed {
        logic [15:0] din;
        logic [7:0]  ns;
        logic        ia;
        logic        ha;
    } cpl_t;

    req_t exp_req[$];
    cpl_t exp_cpl[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Phase enables for the next rising edge: ce_1, idle, ce_2, idle.
    int ph = 0;
    always @(posedge clk) begin
        #2;
        ph   = (ph + 1) % 4;
        ce_1 = (ph == 0);
        ce_2 = (ph == 2);
    end

    // Backend model.
    logic        auto_ack = 1'b0;
    int          ack_delay = 1;
    logic [15:0] rdata_v = 16'd0;
    int          stray_req = 0;
    int          stray_done = 0;
    int          ack_cnt = 0;
    logic        acked = 1'b0;
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (stray_req != stray_done) begin
            mem_ack    = 1'b1;
            mem_rdata  = 16'h7777;
            stray_done = stray_req;
        end else if (auto_ack && mem_req_s && !acked) begin
            ack_cnt++;
            if (ack_cnt == ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata_v;
                acked     = 1'b1;
            end
        end
        if (!mem_req_s) begin
            acked   = 1'b0;
            ack_cnt = 0;
        end
    end

    // Monitor: pops expectations when a request appears or the CPU sees ready.
    logic in_cyc = 1'b0, pend = 1'b0, req_seen = 1'b0;
    int   ns = 0;
    int   n_intack = 0, n_halt = 0, n_berr = 0;
    cpl_t cur;
    req_t rq;
    always @(negedge clk) begin
        if (d0_intack) n_intack++;
        if (d0_halt) n_halt++;
        if (d0_berr) n_berr++;
        if (reset) begin
            in_cyc = 1'b0;
            pend   = 1'b0;
        end else begin
            if (pend) begin
                check("cpl_pulses_ready", {intack_s, halt_s, n_ready_s}, {cur.ia, cur.ha, 1'b1});
                pend = 1'b0;
            end
            if (ce_2) begin
                if (!in_cyc) begin
                    if (!n_bcyst) begin
                        in_cyc = 1'b1;
                        ns     = 0;
                    end
                end else begin
                    ns++;
                    if (!n_ready_s) begin
                        in_cyc = 1'b0;
                        n_checks++;
                        if (exp_cpl.size() == 0) begin
                            n_fail++;
                            $display("FAIL cpl_unexpected: got completion expected none");
                        end else begin
                            cur = exp_cpl.pop_front();
                            check("cpl_din", cpu_din_s, cur.din);
                            check("cpl_samples", ns, cur.ns);
                            pend = 1'b1;
                        end
                    end
                end
            end
        end
        if (mem_req_s && !req_seen) begin
            req_seen = 1'b1;
            if (exp_req.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL req_unexpected: got req %h expected none", req_s);
            end else begin
                rq = exp_req.pop_front();
                check("req_fields", req_s, rq);
            end
        end
        if (!mem_req_s) req_seen = 1'b0;
    end

    task automatic start_cycle(input logic [23:0] a, input logic ube_n, input logic mio,
                               input logic rw, input logic b1, input logic b0,
                               input logic [15:0] dout);
        do @(negedge clk); while (!ce_1);
        @(posedge clk);
        #1;
        n_bcyst = 1'b0; addr = a; n_ube = ube_n; m_io = mio; r_w = rw;
        busst1 = b1; busst0 = b0; cpu_dout = dout;
        do @(negedge clk); while (!ce_2);
        @(posedge clk);
        #1;
        n_bcyst = 1'b1;
    endtask

    task automatic cpu_cycle(input logic [23:0] a, input logic ube_n, input logic mio,
                             input logic rw, input logic b1, input logic b0,
                             input logic [15:0] dout);
        int guard;
        start_cycle(a, ube_n, mio, rw, b1, b0, dout);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(ce_2 && !n_ready_s) && guard < 200);
        if (guard >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL cycle_timeout: got n_ready high for %0d clks expected low", guard);
        end
        @(posedge clk);
        repeat (24) @(negedge clk);
    endtask

    logic nr_min;
    int   g;
    initial begin
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cpu_din", d0_cpu_din, 16'hFFFF);
        check("rst_ready_req", {d0_n_ready, d0_mem_req, d0_mem_io, d0_mem_we}, 4'b1000);
        check("rst_addr_be", {d0_mem_addr, d0_mem_be}, 25'd0);
        check("rst_wdata", d0_mem_wdata, 16'd0);
        check("rst_pulses", {d0_intack, d0_halt, d0_berr}, 3'b000);

        // Zero-wait memory word read.
        sel = 1'b0; auto_ack = 1'b1; ack_delay = 1; rdata_v = 16'hBEEF;
        exp_req.push_back('{io: 1'b0, we: 1'b0, a: 23'h0091A2, be: 2'b11, wd: 16'h1111});
        exp_cpl.push_back('{din: 16'hBEEF, ns: 8'd1, ia: 1'b0, ha: 1'b0});
        cpu_cycle(24'h012344, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1111);

        // Odd byte write with two memory wait states; cpu_din must not change.
        sel = 1'b1; rdata_v = 16'hDEAD;
        exp_req.push_back('{io: 1'b0, we: 1'b1, a: 23'h000080, be: 2'b10, wd: 16'h5A00});
        exp_cpl.push_back('{din: 16'hBEEF, ns: 8'd3, ia: 1'b0, ha: 1'b0});
        cpu_cycle(24'h000101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h5A00);

        // I/O read with a late backend ack.
        sel = 1'b0; ack_delay = 10; rdata_v = 16'h1234;
        exp_req.push_back('{io: 1'b1, we: 1'b0, a: 23'h000020, be: 2'b11, wd: 16'h0000});
        exp_cpl.push_back('{din: 16'h1234, ns: 8'd4, ia: 1'b0, ha: 1'b0});
        cpu_cycle(24'h000040, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);

        // INTA pair.
        int_vector = 8'h21;
        exp_cpl.push_back('{din: 16'hFFFF, ns: 8'd2, ia: 1'b0, ha: 1'b0});
        cpu_cycle(24'h000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        exp_cpl.push_back('{din: 16'hFF21, ns: 8'd2, ia: 1'b1, ha: 1'b0});
        cpu_cycle(24'h000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

        // HALT.
        exp_cpl.push_back('{din: 16'hFF21, ns: 8'd2, ia: 1'b0, ha: 1'b1});
        cpu_cycle(24'h000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);

        // Invalid status code: error pulse, completes as an all-ones read.
        exp_cpl.push_back('{din: 16'hFFFF, ns: 8'd2, ia: 1'b0, ha: 1'b0});
        cpu_cycle(24'h000000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);

        // Reset during ACCESS, after a second cycle start while busy.
        auto_ack = 1'b0;
        exp_req.push_back('{io: 1'b0, we: 1'b0, a: 23'h000200, be: 2'b11, wd: 16'h0000});
        start_cycle(24'h000400, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        g = 0;
        while (!d0_mem_req && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("t7_req_up", d0_mem_req, 1'b1);
        start_cycle(24'h000400, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        repeat (2) @(negedge clk);
        check("t7_still_req", d0_mem_req, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t7_rst_req_ready", {d0_mem_req, d0_n_ready}, 2'b01);
        @(posedge clk);
        #1;
        stray_req++;
        nr_min = 1'b1;
        repeat (10) begin
            @(negedge clk);
            nr_min = nr_min & d0_n_ready;
        end
        check("t7_stray_ready", nr_min, 1'b1);
        check("t7_stray_din", d0_cpu_din, 16'hFFFF);

        // Recovery: lower-byte read, ack exactly at the first sampling edge.
        auto_ack = 1'b1; ack_delay = 2; rdata_v = 16'h00AB;
        exp_req.push_back('{io: 1'b0, we: 1'b0, a: 23'h000001, be: 2'b01, wd: 16'h0000});
        exp_cpl.push_back('{din: 16'h00AB, ns: 8'd2, ia: 1'b0, ha: 1'b0});
        cpu_cycle(24'h000002, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);

        check("end_req_queue", exp_req.size(), 0);
        check("end_cpl_queue", exp_cpl.size(), 0);
        check("intack_pulses", n_intack, 1);
        check("halt_pulses", n_halt, 1);
        check("bus_error_pulses", n_berr, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
